// File: rtl/priority_arbiter_pkg.sv
// Shared parameter defaults and index-width helper for the priority arbiter slice.
package priority_arbiter_pkg;

    localparam int DEFAULT_NUM_REQUEST   = 3;
    localparam int DEFAULT_REQUEST_WIDTH = 64;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Combinational round-robin search: first set bit of valid_i at or after start_i, with wrap.
module rr_find_first
    import priority_arbiter_pkg::*;
#(
    parameter  int NUM_REQUEST = DEFAULT_NUM_REQUEST,
    localparam int IDX_W       = idx_width(NUM_REQUEST)
) (
    input  logic [NUM_REQUEST-1:0] valid_i,
    input  logic [IDX_W-1:0]       start_i,
    output logic                   found_o,
    output logic [IDX_W-1:0]       index_o
);

    int cand;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        found_o = 1'b0;
        index_o = '0;
        cand    = 0;
        for (int off = 0; off < NUM_REQUEST; off++) begin
            cand = int'(start_i) + off;
            if (cand >= NUM_REQUEST) begin
                cand = cand - NUM_REQUEST;
            end
            // Constant bit selects only; the rotated position is matched by comparison.
            for (int i = 0; i < NUM_REQUEST; i++) begin
                if (!found_o && valid_i[i] && (cand == i)) begin
                    found_o = 1'b1;
                    index_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Critical-first / round-robin arbiter feeding a single registered output slot.
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int NUM_REQUEST                  = DEFAULT_NUM_REQUEST,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = DEFAULT_REQUEST_WIDTH
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in
);

    localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int IDX_W = idx_width(NUM_REQUEST);

    logic [W-1:0]           request_q, request_d;
    logic                   valid_q, valid_d;
    logic [NUM_REQUEST-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic                   crit_found;
    logic [IDX_W-1:0]       crit_idx;
    logic                   rr_found;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       rr_start;
    logic [IDX_W-1:0]       winner;
    logic [W-1:0]           winner_payload;

    assign rr_start = (last_q == IDX_W'(NUM_REQUEST - 1)) ? '0 : last_q + IDX_W'(1);

    rr_find_first #(
        .NUM_REQUEST (NUM_REQUEST)
    ) u_rr_find_first (
        .valid_i (request_valid_flatted_in),
        .start_i (rr_start),
        .found_o (rr_found),
        .index_o (rr_idx)
    );

    // Critical requests bypass the rotation: lowest valid critical index wins.
    always_comb begin
        crit_found = 1'b0;
        crit_idx   = '0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (!crit_found && request_valid_flatted_in[i] && request_critical_flatted_in[i]) begin
                crit_found = 1'b1;
                crit_idx   = IDX_W'(i);
            end
        end
    end

    assign winner = crit_found ? crit_idx : rr_idx;

    always_comb begin
        winner_payload = '0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (winner == IDX_W'(i)) begin
                winner_payload = request_flatted_in[i*W +: W];
            end
        end
    end

    // A full slot only drains on issue_ack_in; a load happens only from an empty slot,
    // which enforces the two-cycle grant spacing.
    always_comb begin
        request_d = request_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ack_d     = '0;
        if (valid_q) begin
            if (issue_ack_in) begin
                valid_d = 1'b0;
            end
        end else if (rr_found) begin
            valid_d   = 1'b1;
            request_d = winner_payload;
            last_d    = winner;
            for (int i = 0; i < NUM_REQUEST; i++) begin
                ack_d[i] = (winner == IDX_W'(i));
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    // The payload register is reset too, since request_out must read zero during reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            request_q <= '0;
            valid_q   <= 1'b0;
            ack_q     <= '0;
            last_q    <= '0;
        end else begin
            request_q <= request_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
            last_q    <= last_d;
        end
    end

    assign request_out       = request_q;
    assign request_valid_out = valid_q;
    assign issue_ack_out     = ack_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter (3 requesters, 64-bit payloads).
module tb_priority_arbiter;

    localparam int N = 3;
    localparam int W = 64;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N*W-1:0] request_flatted_in;
    logic [N-1:0]   request_valid_flatted_in;
    logic [N-1:0]   request_critical_flatted_in;
    logic [N-1:0]   issue_ack_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic           issue_ack_in;

    int checks = 0;
    int errors = 0;

    priority_arbiter #(
        .NUM_REQUEST                  (N),
        .SINGLE_REQUEST_WIDTH_IN_BITS (W)
    ) dut (
        .clk_in                      (clk_in),
        .reset_in                    (reset_in),
        .request_flatted_in          (request_flatted_in),
        .request_valid_flatted_in    (request_valid_flatted_in),
        .request_critical_flatted_in (request_critical_flatted_in),
        .issue_ack_out               (issue_ack_out),
        .request_out                 (request_out),
        .request_valid_out           (request_valid_out),
        .issue_ack_in                (issue_ack_in)
    );

    always #5 clk_in = ~clk_in;

    // Outputs are observed 1 ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_payload(input int idx, input logic [W-1:0] val);
        request_flatted_in[idx*W +: W] = val;
    endtask

    task automatic do_reset();
        request_valid_flatted_in    = '0;
        request_critical_flatted_in = '0;
        request_flatted_in          = '0;
        issue_ack_in                = 1'b0;
        reset_in                    = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic drain();
        request_valid_flatted_in    = '0;
        request_critical_flatted_in = '0;
        issue_ack_in                = 1'b1;
        tick();
        issue_ack_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        request_valid_flatted_in    = '1;
        request_critical_flatted_in = '0;
        request_flatted_in          = '1;
        issue_ack_in                = 1'b0;
        reset_in                    = 1'b1;
        tick();
        tick();
        checks++;
        if (request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", request_valid_out);
        end
        checks++;
        if (request_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", request_out);
        end
        checks++;
        if (issue_ack_out !== 3'b000) begin
            errors++;
            $display("FAIL reset_ack: got %b want 000", issue_ack_out);
        end
        reset_in                 = 1'b0;
        request_valid_flatted_in = '0;
        tick();
    endtask

    // All three always valid; expected order 16,32,0,17,33,1,...,47,15.
    task automatic test_round_robin();
        int cnt [N];
        int k;
        int exp_r;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            set_payload(i, W'(i * 16));
        end
        request_valid_flatted_in = 3'b111;
        k = 0;
        for (int cyc = 0; cyc < 400 && k < 48; cyc++) begin
            tick();
            if (issue_ack_out !== 3'b000) begin
                exp_r = (k + 1) % N;
                checks++;
                if (issue_ack_out !== (3'b001 << exp_r) || request_out !== W'(exp_r * 16 + k / 3)) begin
                    errors++;
                    $display("FAIL rr_item%0d: ack=%b data=%0d want ack=%b data=%0d",
                             k, issue_ack_out, request_out, 3'b001 << exp_r, exp_r * 16 + k / 3);
                end
                k++;
                for (int i = 0; i < N; i++) begin
                    if (issue_ack_out[i]) begin
                        cnt[i]++;
                        set_payload(i, W'(i * 16 + cnt[i]));
                        if (cnt[i] >= 16) request_valid_flatted_in[i] = 1'b0;
                    end
                end
            end
            issue_ack_in = request_valid_out;
        end
        checks++;
        if (k != 48) begin
            errors++;
            $display("FAIL rr_count: got %0d items want 48", k);
        end
        drain();
    endtask

    task automatic test_single();
        do_reset();
        set_payload(2, 64'hAB);
        request_valid_flatted_in = 3'b100;
        tick();
        checks++;
        if (issue_ack_out !== 3'b100 || request_out !== 64'hAB || request_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL single_first: ack=%b data=%h vld=%b want ack=100 data=ab vld=1",
                     issue_ack_out, request_out, request_valid_out);
        end
        issue_ack_in = 1'b1;
        set_payload(2, 64'hCD);
        tick();
        issue_ack_in = 1'b0;
        checks++;
        if (request_valid_out !== 1'b0 || issue_ack_out !== 3'b000) begin
            errors++;
            $display("FAIL single_gap: vld=%b ack=%b want vld=0 ack=000", request_valid_out, issue_ack_out);
        end
        tick();
        checks++;
        if (issue_ack_out !== 3'b100 || request_out !== 64'hCD) begin
            errors++;
            $display("FAIL single_second: ack=%b data=%h want ack=100 data=cd", issue_ack_out, request_out);
        end
        drain();
    endtask

    task automatic one_grant(input string name, input logic [N-1:0] vld, input logic [N-1:0] crit,
                             input logic [N-1:0] exp_ack);
        request_valid_flatted_in    = vld;
        request_critical_flatted_in = crit;
        tick();
        checks++;
        if (issue_ack_out !== exp_ack) begin
            errors++;
            $display("FAIL %s: ack=%b want %b", name, issue_ack_out, exp_ack);
        end
        drain();
    endtask

    // last_granted sequence: 0 -> 2 -> 2 -> 0 -> 2 -> 0
    task automatic test_critical();
        do_reset();
        set_payload(0, 64'h10);
        set_payload(1, 64'h11);
        set_payload(2, 64'h12);
        one_grant("crit_r2_last0", 3'b101, 3'b100, 3'b100);
        one_grant("crit_r2_over_rr", 3'b101, 3'b100, 3'b100);
        one_grant("crit_both_low", 3'b101, 3'b101, 3'b001);
        one_grant("rr_last0", 3'b101, 3'b000, 3'b100);
        one_grant("rr_last2_wrap", 3'b101, 3'b000, 3'b001);
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < N; i++) set_payload(i, W'(256 + i));
        request_valid_flatted_in = 3'b111;
        tick();
        checks++;
        if (issue_ack_out !== 3'b010 || request_out !== 64'h101) begin
            errors++;
            $display("FAIL hold_grant: ack=%b data=%h want ack=010 data=101", issue_ack_out, request_out);
        end
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) set_payload(i, W'(512 + c * 4 + i));
            tick();
            checks++;
            if (request_valid_out !== 1'b1 || request_out !== 64'h101 || issue_ack_out !== 3'b000) begin
                errors++;
                $display("FAIL hold_cycle%0d: vld=%b data=%h ack=%b want vld=1 data=101 ack=000",
                         c, request_valid_out, request_out, issue_ack_out);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < N; i++) set_payload(i, W'(512 + i));
        request_valid_flatted_in = 3'b111;
        tick();
        checks++;
        if (issue_ack_out !== 3'b010 || request_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: ack=%b vld=%b want ack=010 vld=1", issue_ack_out, request_valid_out);
        end
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if (request_valid_out !== 1'b0 || issue_ack_out !== 3'b000 || request_out !== '0) begin
            errors++;
            $display("FAIL async_assert: vld=%b ack=%b data=%h want vld=0 ack=000 data=0",
                     request_valid_out, issue_ack_out, request_out);
        end
        #2 reset_in = 1'b0;
        tick();
        checks++;
        if (issue_ack_out !== 3'b010 || request_out !== 64'h201) begin
            errors++;
            $display("FAIL async_first: ack=%b data=%h want ack=010 data=201", issue_ack_out, request_out);
        end
        drain();
    endtask

    initial begin
        reset_in                    = 1'b1;
        request_flatted_in          = '0;
        request_valid_flatted_in    = '0;
        request_critical_flatted_in = '0;
        issue_ack_in                = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_critical();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
